// File: rtl/moore_seq_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | moore_seq_tx : serial frame transmitter (sync word, payload, idle gap)    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module moore_seq_tx #(
  parameter int                SYNC_W     = 4,
  parameter logic [SYNC_W-1:0] SYNC       = 4'b1011,
  parameter int                DATA_W     = 8,
  parameter int                GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int c_max_sd = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int c_max    = (c_max_sd > GAP_CYCLES) ? c_max_sd : GAP_CYCLES;
  localparam int c_cnt_w  = $clog2(c_max + 1);

  localparam logic [c_cnt_w-1:0] c_sync_last = c_cnt_w'(SYNC_W - 1);
  localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(DATA_W - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [SYNC_W-1:0]   r_sync;
  logic [DATA_W-1:0]   r_data;

  // Each branch pre-computes the bit for the next cycle so out stays registered.
  always_ff @(posedge clk) begin
    if (!clear) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sync   <= '0;
      r_data   <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          out  <= 1'b0;
          done <= 1'b0;
          if (in_valid) begin
            r_state  <= S_SYNC;
            r_cnt    <= '0;
            r_data   <= in_data;
            r_sync   <= SYNC << 1;
            out      <= SYNC[SYNC_W-1];
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        S_SYNC: begin
          if (r_cnt == c_sync_last) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            out     <= r_data[DATA_W-1];
            r_data  <= r_data << 1;
          end else begin
            r_cnt  <= r_cnt + c_cnt_one;
            out    <= r_sync[SYNC_W-1];
            r_sync <= r_sync << 1;
          end
        end
        S_DATA: begin
          if (r_cnt == c_data_last) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            out     <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + c_cnt_one;
            out    <= r_data[DATA_W-1];
            r_data <= r_data << 1;
          end
        end
        S_GAP: begin
          out  <= 1'b0;
          done <= 1'b0;
          if (r_cnt == c_gap_last) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          out      <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_moore_seq_tx : scoreboard bench for moore_seq_tx (default + swept)     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_moore_seq_tx;

  localparam logic [3:0] c_sync = 4'b1011;

  logic       clk = 1'b0;
  logic       clear, in_valid, in_ready, out, busy, done;
  logic [7:0] in_data;

  logic       clear_b, valid_b, ready_b, out_b, busy_b, done_b;
  logic [3:0] data_b;

  always #5 clk = ~clk;

  moore_seq_tx u_dut (
    .clk      (clk),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  moore_seq_tx #(
    .SYNC_W     (3),
    .SYNC       (3'b110),
    .DATA_W     (4),
    .GAP_CYCLES (3)
  ) u_dut_b (
    .clk      (clk),
    .clear    (clear_b),
    .in_valid (valid_b),
    .in_data  (data_b),
    .in_ready (ready_b),
    .out      (out_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  typedef struct packed {
    logic o;
    logic d;
  } ent_t;

  ent_t q[$];
  int   n_total   = 0;
  int   n_bad     = 0;
  int   n_done    = 0;
  bit   exp_ready = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int k = 3; k >= 0; k--) q.push_back('{o: c_sync[k], d: 1'b0});
    for (int k = 7; k >= 0; k--) q.push_back('{o: d[k], d: 1'b0});
    q.push_back('{o: 1'b0, d: 1'b1});
  endtask

  // One clock: model the accept/reset decision, advance, then score the outputs.
  task automatic step();
    ent_t e;
    if (!clear) q.delete();
    else if (in_valid && exp_ready) push_frame(in_data);
    @(posedge clk);
    #1;
    if (done === 1'b1) n_done++;
    if (q.size() > 0) begin
      e = q.pop_front();
      exp_ready = 1'b0;
      check("out", 32'(out), 32'(e.o));
      check("done", 32'(done), 32'(e.d));
      check("busy", 32'(busy), 32'd1);
      check("in_ready", 32'(in_ready), 32'd0);
    end else begin
      exp_ready = 1'b1;
      check("idle_out", 32'(out), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(in_ready), 32'd1);
    end
  endtask

  logic [11:0] eo_b, ed_b, eb_b, er_b;
  int          done_base;

  initial begin
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear_b  = 1'b0;
    valid_b  = 1'b0;
    data_b   = 4'h0;

    // Reset then idle
    repeat (2) step();
    clear   = 1'b1;
    clear_b = 1'b1;
    repeat (10) step();

    // Single frame 0xA5
    done_base = n_done;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (14) step();
    check("a5_done_count", 32'(n_done - done_base), 32'd1);

    // Back-to-back 0xFF then 0x00 with in_valid held high
    done_base = n_done;
    in_data  = 8'hFF;
    in_valid = 1'b1;
    step();
    in_data = 8'h00;
    repeat (13) step();
    check("b2b_ready_before_2nd", 32'(in_ready), 32'd1);
    step();
    check("b2b_2nd_accept_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    repeat (14) step();
    check("b2b_done_count", 32'(n_done - done_base), 32'd2);

    // Input stability: random in_valid/in_data while busy
    in_data  = 8'h3C;
    in_valid = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Mid-frame reset, with a simultaneous accept request that must be ignored
    done_base = n_done;
    in_data  = 8'hC3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    clear    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    clear    = 1'b1;
    in_valid = 1'b0;
    repeat (2) step();
    check("abort_no_done", 32'(n_done - done_base), 32'd0);
    in_data  = 8'h81;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (14) step();

    // Swept instance: SYNC=110, DATA_W=4, GAP=3, data 0x9, held valid for period check
    eo_b = 12'b1000_0100_1011;
    ed_b = 12'b0000_1000_0000;
    eb_b = 12'b1011_1111_1111;
    er_b = 12'b0100_0000_0000;
    check("b_reset_ready", 32'(ready_b), 32'd1);
    data_b  = 4'h9;
    valid_b = 1'b1;
    step();
    data_b = 4'h6;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("b_out[%0d]", i), 32'(out_b), 32'(eo_b[i]));
      check($sformatf("b_done[%0d]", i), 32'(done_b), 32'(ed_b[i]));
      check($sformatf("b_busy[%0d]", i), 32'(busy_b), 32'(eb_b[i]));
      check($sformatf("b_ready[%0d]", i), 32'(ready_b), 32'(er_b[i]));
      if (i == 11) valid_b = 1'b0;
      else step();
    end
    repeat (12) step();
    check("b_final_ready", 32'(ready_b), 32'd1);
    check("b_final_out", 32'(out_b), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/moore_seq_tx.md
Name: moore_seq_tx

Overview:
- Serial frame transmitter, the sending end of the team's Moore sync-word detection link.
- Accepts a parallel payload word through a valid/ready handshake.
- Emits one bit per clock: the sync word 1011 MSB-first, then the payload MSB-first, then a mandatory idle gap.
- Output is Moore-style: `out` is a registered function of state and shift register only, never of the current-cycle inputs.

Parameters:
- SYNC_W, 4, sync word width in bits (≥1).
- SYNC, 4'b1011, sync word; transmitted MSB first.
- DATA_W, 8, payload width in bits (≥1).
- GAP_CYCLES, 1, idle cycles with out=0 after each frame before accepting the next (≥1).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  payload valid request.
- in_data  input  DATA_W  payload word; sampled only on an accepting edge.
- in_ready  output  1  high only in IDLE; a transfer occurs on a rising edge with in_valid && in_ready.
- out  output  1  serial bit stream; idle level 0.
- busy  output  1  high in SYNC, DATA and GAP.
- done  output  1  one-cycle pulse in the first GAP cycle after the last payload bit.

Behaviour:
- Reset: clear=0 at a rising edge forces the following values next cycle.
  - state=IDLE, out=0, busy=0, done=0, in_ready=1.
  - Bit counter and shift register cleared.
  - clear=1 with no edge has no effect (synchronous).
- States: IDLE, SYNC, DATA, GAP. Encoding is free; illegal state → IDLE with out=0.
- IDLE:
  - out=0.
  - On edge with in_valid=1, in_data is latched into the shift register → SYNC.
  - in_valid=0 → stay in IDLE.
- SYNC: SYNC_W cycles; cycle k (k=0..SYNC_W-1) has out=SYNC[SYNC_W-1-k]. After the last sync bit → DATA.
- DATA: DATA_W cycles; cycle k has out=latched_data[DATA_W-1-k]. After the last payload bit → GAP.
- GAP:
  - GAP_CYCLES cycles with out=0.
  - done=1 in the first GAP cycle only.
  - After the last gap cycle → IDLE.
- Latency: accepting edge at T → first sync bit visible after edge T. Frame occupies SYNC_W+DATA_W cycles. in_ready returns SYNC_W+DATA_W+GAP_CYCLES cycles after T.
- Back-to-back: with in_valid held high, the next accept happens on the first IDLE edge. Minimum frame period is SYNC_W+DATA_W+GAP_CYCLES+1 cycles.
- Input stability:
  - in_data changes during a frame do not affect the bits being sent.
  - in_valid deasserting mid-frame has no effect.
  - in_valid while not ready is ignored and not queued.
- Counters: bit counter sized ceil(log2(max(SYNC_W,DATA_W,GAP_CYCLES)+1)) bits; resets to 0 on each state entry. No wrap inside a state.
- Reset mid-frame: clear=0 aborts the frame immediately. Next cycle out=0, IDLE, done not pulsed.
- Reset wins over a simultaneous accept: in_valid=1 with clear=0 latches nothing.
- Payload is not escaped. A payload containing the sync pattern is the link layer's concern, not this block's.

Test Plan:
- Reset then idle: hold clear=0 for 2 cycles, release, in_valid=0 for 10 cycles → out=0, in_ready=1, busy=0, done=0 throughout.
- Single frame: in_data=8'hA5, in_valid for 1 cycle at edge T → out over the next 12 cycles = 1,0,1,1,1,0,1,0,0,1,0,1. Then out=0 with done=1 in cycle 13, and in_ready=1 from cycle 14.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 → frame 1 = 1011 11111111, one 0 gap, then frame 2 = 1011 00000000. Second accept occurs exactly 14 cycles after the first; two done pulses.
- Input stability: accept 8'h3C, then toggle in_data/in_valid randomly during busy → bitstream equals 1011 00111100 exactly; no extra accept before in_ready.
- Reset mid-frame: accept 8'hC3, assert clear=0 at the 6th frame cycle → out=0 next cycle, no done pulse, in_ready=1. A new frame with 8'h81 then sends 1011 10000001 correctly.
- Parameter sweep: DATA_W=4, SYNC=3'b110, SYNC_W=3, GAP_CYCLES=3, data 4'h9 → out = 1,1,0,1,0,0,1 then 3 zeros. done in the first zero cycle; period 11 cycles.
